instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 8-bit multicycle CPU, directly upstream of the control unit. Holds a small writable instruction memory and a program counter. Presents one 20-bit instruction word on `instr` for exactly as many cycles as the control unit needs to finish that instruction class, then advances. Drives an all-zero bubble whenever nothing is being issued, and stops on a halt word.

## Interface
- `INSTR_WIDTH`, 20: instruction word width; the class field is bits [19:18].
- `ADDR_BITS`, 5: PC width; instruction memory depth is 2^ADDR_BITS.
- `STD_CYCLES`, 3: hold cycles for class 01 (std_op).
- `MEM_CYCLES`, 4: hold cycles for class 10 (loadR) and class 11 (storeR).
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `run` input, 1: level enable for issuing instructions.
- `prog_we` input, 1: instruction memory write strobe.
- `prog_addr` input, ADDR_BITS: instruction memory write address.
- `prog_data` input, INSTR_WIDTH: instruction memory write data.
- `instr` output, INSTR_WIDTH: instruction to the control unit; 0 means bubble.
- `pc` output, ADDR_BITS: address of the next word to fetch.
- `busy` output, 1: high while an instruction is being held on `instr`.
- `halted` output, 1: sticky high once a halt word has been fetched.
- `issue_count` output, 16: number of instructions issued; saturates at 16'hFFFF.

## Operation
- Reset values:
  - `instr`=0, `pc`=0, `busy`=0, `halted`=0, `issue_count`=0.
  - State IDLE; hold counter 0; `first` flag set.
- The instruction memory is not affected by `rst`. Contents are retained across resets, and unwritten locations are undefined.
- Memory write: synchronous on `clk` when `prog_we`=1. Writes are accepted only in IDLE or HALT; in ISSUE they are ignored.
- The memory is read combinationally at `pc`. `instr` is always registered.
- States:
  - IDLE: `instr`=0, `busy`=0. If `run`=1, perform a fetch at the next edge.
  - ISSUE: `instr` holds the word, `busy`=1. The hold counter decrements each cycle. At counter 0:
    - if `run`=1, perform a fetch at the same edge (back-to-back, no bubble);
    - else `instr`<=0 and go to IDLE.
  - HALT: `instr`=0, `busy`=0, `halted`=1. Leave only via `rst`.
- Fetch, performed at the edge. Let W = mem[`pc`].
  - If W[19:18]==00 (halt word): `instr`<=0, `halted`<=1, go to HALT. `pc` is unchanged and still points at the halt word; `issue_count` is unchanged.
  - Otherwise:
    - `instr`<=W; `pc`<=`pc`+1, wrapping from 2^ADDR_BITS-1 to 0.
    - `issue_count`<=`issue_count`+1, saturating.
    - Hold length N = STD_CYCLES for class 01, MEM_CYCLES for class 10/11.
    - If `first` is set, N is increased by 1 to cover the control unit's RESET→DECODE transition, and `first` is cleared.
    - Hold counter <= N-1; go to ISSUE.
- Dropping `run` mid-hold does not truncate the current instruction. The hold completes, then the block goes to IDLE; `pc` already points past the issued word.
- `rst` mid-operation clears all registers immediately to their reset values and sets `first` again. The memory is preserved.

## Timing
- Fetch latency: `instr` is valid in the cycle after the edge at which `run`=1 is sampled in IDLE.
- A word is held on `instr` for exactly N consecutive cycles.
- With `run` held high, consecutive non-halt words follow with zero bubble cycles.
- `busy` and `instr`≠0 coincide exactly.
- `pc` and `issue_count` update at the same edge that loads `instr`.
- Simultaneous `prog_we` and fetch in IDLE: the fetch reads the old memory contents; the write takes effect for later reads.

## Test plan
- Load mem[0]=20'h4_1230 (std), mem[1]=20'h8_0500 (loadR), mem[2]=0; reset; hold `run`=1.
  - Required: word 0 held 4 cycles (first), word 1 held 4 cycles, then `instr`=0 and `halted`=1.
  - Final values: `pc`=2, `issue_count`=2.
- Load mem[0..2] with three std words, mem[3]=0; run.
  - Required: hold lengths 4, 3, 3 with no gap between words; halt with `pc`=3, `issue_count`=3.
- Drop `run` in the second cycle of a 3-cycle std hold.
  - Required: the word stays for its full hold, then `instr`=0, IDLE, `busy`=0.
  - Raising `run` again fetches the next word with N=STD_CYCLES (no first-cycle extension).
- Assert `prog_we` to address 7 during ISSUE.
  - Required: memory location 7 is unchanged, verified later by fetching it.
  - The same write performed in IDLE takes effect.
- PC wrap with ADDR_BITS=2: fill all four words with nonzero std words and run.
  - Required: `pc` sequence 1, 2, 3, 0, 1; `issue_count` keeps incrementing.
- Assert `rst` mid-hold of a loadR.
  - Required: all outputs return to reset values immediately.
  - After release with `run`=1, mem[0] is re-fetched with the first-cycle extension, and memory contents are intact.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: run/program controls in, issued instruction and status out.
interface instr_fetch_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5
);
    logic                   run;
    logic                   prog_we;
    logic [ADDR_BITS-1:0]   prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_BITS-1:0]   pc;
    logic                   busy;
    logic                   halted;
    logic [15:0]            issue_count;

    modport master (
        output run, prog_we, prog_addr, prog_data,
        input  instr, pc, busy, halted, issue_count
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data,
        output instr, pc, busy, halted, issue_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: writable instruction memory plus PC; holds each word on
// instr for its class-dependent cycle count, emits zero bubbles, stops on halt.
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int STD_CYCLES  = 3,
    parameter int MEM_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

    // Counter must also cover the one-cycle first-instruction extension.
    localparam int HOLD_MAX = (MEM_CYCLES > STD_CYCLES) ? MEM_CYCLES : STD_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    state_t                 state, state_n;
    logic [INSTR_WIDTH-1:0] instr_q, instr_n;
    logic [ADDR_BITS-1:0]   pc_q, pc_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;
    logic                   first_q, first_n;
    logic [15:0]            count_q, count_n;

    logic [INSTR_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];
    logic [INSTR_WIDTH-1:0] word;
    logic [1:0]             cls;
    logic                   do_fetch;
    int                     hold_len;

    assign word = mem[pc_q];
    assign cls  = word[INSTR_WIDTH-1 -: 2];

    // Memory survives reset; writes are locked out while a word is on the bus.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state != ISSUE)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b1;
            count_q <= '0;
        end else begin
            state   <= state_n;
            instr_q <= instr_n;
            pc_q    <= pc_n;
            cnt_q   <= cnt_n;
            first_q <= first_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        instr_n  = instr_q;
        pc_n     = pc_q;
        cnt_n    = cnt_q;
        first_n  = first_q;
        count_n  = count_q;
        hold_len = 0;
        do_fetch = bus.run && (state == IDLE || (state == ISSUE && cnt_q == '0));

        if (state == ISSUE) begin
            if (cnt_q != '0) begin
                cnt_n = cnt_q - 1'b1;
            end else if (!bus.run) begin
                instr_n = '0;
                state_n = IDLE;
            end
        end

        if (do_fetch) begin
            if (cls == 2'b00) begin
                // Halt word: pc stays on it so a debugger can see where we stopped.
                instr_n = '0;
                state_n = HALT;
            end else begin
                instr_n = word;
                pc_n    = pc_q + 1'b1;
                if (count_q != '1)
                    count_n = count_q + 1'b1;
                hold_len = (cls == 2'b01) ? STD_CYCLES : MEM_CYCLES;
                if (first_q)
                    hold_len = hold_len + 1;
                cnt_n   = CNT_W'(hold_len - 1);
                first_n = 1'b0;
                state_n = ISSUE;
            end
        end
    end

    always_comb begin
        bus.instr       = instr_q;
        bus.pc          = pc_q;
        bus.busy        = (state == ISSUE);
        bus.halted      = (state == HALT);
        bus.issue_count = count_q;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: hold lengths, run drop, write lockout,
// PC wrap (2-bit PC instance) and mid-hold reset.
module tb_instr_fetch;
    logic clk;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    instr_fetch_if #(.INSTR_WIDTH(20), .ADDR_BITS(5)) bus ();
    instr_fetch_if #(.INSTR_WIDTH(20), .ADDR_BITS(2)) bus2 ();

    instr_fetch #(.INSTR_WIDTH(20), .ADDR_BITS(5), .STD_CYCLES(3), .MEM_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    instr_fetch #(.INSTR_WIDTH(20), .ADDR_BITS(2), .STD_CYCLES(3), .MEM_CYCLES(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [4:0] a, input logic [19:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        step();
        bus.prog_we   = 1'b0;
    endtask

    task automatic prog2(input logic [1:0] a, input logic [19:0] d);
        bus2.prog_we   = 1'b1;
        bus2.prog_addr = a;
        bus2.prog_data = d;
        step();
        bus2.prog_we   = 1'b0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Expect word w on instr (with busy) for exactly n consecutive cycles.
    task automatic hold(input string tag, input logic [19:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(bus.instr), 32'(w));
            chk({tag, "_busy"}, 32'(bus.busy), 'd1);
            step();
        end
    endtask

    task automatic chk_halt(input string tag, input int pc_exp, input int cnt_exp);
        chk({tag, "_instr"},  32'(bus.instr),       'd0);
        chk({tag, "_busy"},   32'(bus.busy),        'd0);
        chk({tag, "_halted"}, 32'(bus.halted),      'd1);
        chk({tag, "_pc"},     32'(bus.pc),          32'(pc_exp));
        chk({tag, "_cnt"},    32'(bus.issue_count), 32'(cnt_exp));
    endtask

    initial begin
        rst = 1'b1;
        bus.run = 1'b0;  bus.prog_we = 1'b0;  bus.prog_addr = '0;  bus.prog_data = '0;
        bus2.run = 1'b0; bus2.prog_we = 1'b0; bus2.prog_addr = '0; bus2.prog_data = '0;
        step();

        // std then loadR then halt
        prog(5'd0, 20'h41230);
        prog(5'd1, 20'h80500);
        prog(5'd2, 20'h00000);
        chk("rst_instr",  32'(bus.instr),       'd0);
        chk("rst_pc",     32'(bus.pc),          'd0);
        chk("rst_busy",   32'(bus.busy),        'd0);
        chk("rst_halted", 32'(bus.halted),      'd0);
        chk("rst_cnt",    32'(bus.issue_count), 'd0);
        rst = 1'b0;
        bus.run = 1'b1;
        step();
        chk("t1_pc1",  32'(bus.pc),          'd1);
        chk("t1_cnt1", 32'(bus.issue_count), 'd1);
        hold("t1_w0", 20'h41230, 4);
        chk("t1_pc2", 32'(bus.pc), 'd2);
        hold("t1_w1", 20'h80500, 4);
        chk_halt("t1_halt", 2, 2);
        step();
        chk_halt("t1_sticky", 2, 2);

        // three std words back-to-back (writes accepted while halted)
        bus.run = 1'b0;
        prog(5'd0, 20'h40001);
        prog(5'd1, 20'h40002);
        prog(5'd2, 20'h40003);
        prog(5'd3, 20'h00000);
        rst_pulse();
        bus.run = 1'b1;
        step();
        hold("t2_w0", 20'h40001, 4);
        hold("t2_w1", 20'h40002, 3);
        hold("t2_w2", 20'h40003, 3);
        chk_halt("t2_halt", 3, 3);

        // drop run in second cycle of a std hold
        bus.run = 1'b0;
        prog(5'd0, 20'h40011);
        prog(5'd1, 20'h40012);
        prog(5'd2, 20'h40013);
        rst_pulse();
        bus.run = 1'b1;
        step();
        hold("t3_w0", 20'h40011, 4);
        hold("t3_w1a", 20'h40012, 1);
        bus.run = 1'b0;
        hold("t3_w1b", 20'h40012, 2);
        chk("t3_idle_instr",  32'(bus.instr),  'd0);
        chk("t3_idle_busy",   32'(bus.busy),   'd0);
        chk("t3_idle_pc",     32'(bus.pc),     'd2);
        chk("t3_idle_halted", 32'(bus.halted), 'd0);
        step();
        chk("t3_idle2_instr", 32'(bus.instr), 'd0);
        bus.run = 1'b1;
        step();
        hold("t3_w2", 20'h40013, 3);
        chk_halt("t3_halt", 3, 3);

        // write to 7 during ISSUE must be ignored
        bus.run = 1'b0;
        for (int i = 0; i < 7; i++) prog(5'(i), 20'h40000 + 20'(i * 'h10));
        prog(5'd7, 20'h40777);
        prog(5'd8, 20'h00000);
        rst_pulse();
        bus.run = 1'b1;
        step();
        bus.prog_we = 1'b1; bus.prog_addr = 5'd7; bus.prog_data = 20'h40BAD;
        hold("t4_w0a", 20'h40000, 1);
        bus.prog_we = 1'b0;
        hold("t4_w0b", 20'h40000, 3);
        for (int i = 1; i < 7; i++) hold("t4_wi", 20'h40000 + 20'(i * 'h10), 3);
        hold("t4_w7_kept", 20'h40777, 3);
        chk_halt("t4_halt", 8, 8);

        // same write in IDLE takes effect; write+fetch in same IDLE edge reads old word
        bus.run = 1'b0;
        rst_pulse();
        prog(5'd7, 20'h40BAD);
        bus.prog_we = 1'b1; bus.prog_addr = 5'd0; bus.prog_data = 20'h40F00;
        bus.run = 1'b1;
        step();
        bus.prog_we = 1'b0;
        hold("t4_old_w0", 20'h40000, 4);
        for (int i = 1; i < 7; i++) hold("t4_wj", 20'h40000 + 20'(i * 'h10), 3);
        hold("t4_w7_new", 20'h40BAD, 3);
        chk_halt("t4_halt2", 8, 8);
        bus.run = 1'b0;
        rst_pulse();
        bus.run = 1'b1;
        step();
        chk("t4_new_w0", 32'(bus.instr), 'h40F00);

        // reset in the middle of a loadR hold
        bus.run = 1'b0;
        rst_pulse();
        prog(5'd0, 20'h80AAA);
        prog(5'd1, 20'h00000);
        rst_pulse();
        bus.run = 1'b1;
        step();
        hold("t6_pre", 20'h80AAA, 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_instr",  32'(bus.instr),       'd0);
        chk("t6_rst_pc",     32'(bus.pc),          'd0);
        chk("t6_rst_busy",   32'(bus.busy),        'd0);
        chk("t6_rst_halted", 32'(bus.halted),      'd0);
        chk("t6_rst_cnt",    32'(bus.issue_count), 'd0);
        step();
        rst = 1'b0;
        step();
        chk("t6_pc", 32'(bus.pc),          'd1);
        chk("t6_cnt", 32'(bus.issue_count), 'd1);
        hold("t6_refetch", 20'h80AAA, 5);
        chk_halt("t6_halt", 1, 1);

        // PC wrap on the 2-bit-PC instance
        bus.run = 1'b0;
        for (int i = 0; i < 4; i++) prog2(2'(i), 20'h41000 + 20'(i));
        rst_pulse();
        bus2.run = 1'b1;
        step();
        chk("t5_pc1", 32'(bus2.pc), 'd1);
        chk("t5_c1",  32'(bus2.issue_count), 'd1);
        chk("t5_i1",  32'(bus2.instr), 'h41000);
        repeat (4) step();
        chk("t5_pc2", 32'(bus2.pc), 'd2);
        chk("t5_c2",  32'(bus2.issue_count), 'd2);
        chk("t5_i2",  32'(bus2.instr), 'h41001);
        repeat (3) step();
        chk("t5_pc3", 32'(bus2.pc), 'd3);
        chk("t5_c3",  32'(bus2.issue_count), 'd3);
        repeat (3) step();
        chk("t5_pc0", 32'(bus2.pc), 'd0);
        chk("t5_c4",  32'(bus2.issue_count), 'd4);
        chk("t5_i4",  32'(bus2.instr), 'h41003);
        repeat (3) step();
        chk("t5_pc1b", 32'(bus2.pc), 'd1);
        chk("t5_c5",   32'(bus2.issue_count), 'd5);
        chk("t5_i5",   32'(bus2.instr), 'h41000);
        bus2.run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
